// File: rtl/act_sched_pkg.sv
// Shared types, default widths and address-map helpers for act_lut_scheduler.
// ACT_SCHED_INDEX_REUSE_EN adds the CALC state used by the index-reuse path.
package act_sched_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_FRAC_W = 4;
  localparam int unsigned DEF_ADDR_W = DEF_DATA_W - DEF_FRAC_W;

`ifdef ACT_SCHED_INDEX_REUSE_EN
  typedef enum logic [2:0] {IDLE, RD_BASE, RD_NEXT, WAIT_NEXT, RESP, CALC} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD_BASE, RD_NEXT, WAIT_NEXT, RESP} state_t;
`endif

  // Offset-binary mapping so the most negative input lands on address 0
  function automatic logic [DEF_ADDR_W-1:0] base_addr_f(input logic [DEF_ADDR_W-1:0] hi);
    return hi ^ DEF_ADDR_W'(1 << (DEF_ADDR_W - 1));
  endfunction

  // Top entry has no successor; interpolate against itself
  function automatic logic [DEF_ADDR_W-1:0] next_addr_f(input logic [DEF_ADDR_W-1:0] a);
    return (a == '1) ? a : a + DEF_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/act_interp.sv
// Combinational linear interpolator: y = base + floor((next - base) * remaining / 2^FRAC_W).
module act_interp #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FRAC_W = 4
) (
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] next,
  input  logic [FRAC_W-1:0] remaining,
  output logic [DATA_W-1:0] y
);

  localparam int unsigned PROD_W = DATA_W + FRAC_W + 1;

  logic signed [DATA_W:0]   diff;
  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] shifted;
  logic signed [PROD_W-1:0] sum;

  assign diff    = $signed({next[DATA_W-1], next}) - $signed({base[DATA_W-1], base});
  assign prod    = PROD_W'(diff) * $signed({{(DATA_W + 1){1'b0}}, remaining});
  assign shifted = prod >>> FRAC_W;
  // Result lies between base and next, so truncation is lossless
  assign sum     = PROD_W'($signed(base)) + shifted;
  assign y       = DATA_W'(sum);

endmodule

// File: rtl/act_lut_scheduler.sv
// Shares one activation LUT and interpolator among N_REQ requesters (round-robin).
// Optional ACT_SCHED_INDEX_REUSE_EN skips the ROM fetch when the table index repeats.
module act_lut_scheduler
  import act_sched_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned FRAC_W = DEF_FRAC_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*DATA_W-1:0]   req_x,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_rdata,
  output logic                      rsp_valid,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]         rsp_y,
  input  logic                      rsp_ready
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  state_t            state, state_d;
  logic [ID_W-1:0]   rr_ptr, grant_id, pick, id_q;
  logic [N_REQ-1:0]  rot;
  int unsigned       grant_sum;
  logic [DATA_W-1:0] sel_x, x_q, base_q, interp_next, interp_y;
  logic [ADDR_W-1:0] sel_base_addr, cur_base_addr, rom_addr_d;
  logic              accept, rom_en_d, load_base, load_rsp, rsp_valid_d, tag_hit;

  // Round-robin: rotate so rr_ptr is bit 0, pick lowest, rotate back
  always_comb begin
    rot  = N_REQ'({req_valid, req_valid} >> rr_ptr);
    pick = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) pick = ID_W'(i);
    end
    grant_sum = 32'(pick) + 32'(rr_ptr);
    if (grant_sum >= N_REQ) grant_sum = grant_sum - N_REQ;
    grant_id = ID_W'(grant_sum);
  end

  assign sel_x         = req_x[32'(grant_id)*DATA_W +: DATA_W];
  assign sel_base_addr = base_addr_f(sel_x[DATA_W-1:FRAC_W]);
  assign cur_base_addr = base_addr_f(x_q[DATA_W-1:FRAC_W]);

`ifdef ACT_SCHED_INDEX_REUSE_EN
  logic [DATA_W-1:0] next_q;
  logic [ADDR_W-1:0] tag_addr;
  logic              tag_valid;

  assign tag_hit     = tag_valid && (tag_addr == sel_base_addr);
  assign interp_next = (state == CALC) ? next_q : rom_rdata;

  // base_q doubles as the tag's base entry; it only changes on a fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_q    <= '0;
      tag_addr  <= '0;
      tag_valid <= 1'b0;
    end else if (state == WAIT_NEXT) begin
      next_q    <= rom_rdata;
      tag_addr  <= cur_base_addr;
      tag_valid <= 1'b1;
    end
  end
`else
  assign tag_hit     = 1'b0;
  assign interp_next = rom_rdata;
`endif

  act_interp #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_interp (
    .base      (base_q),
    .next      (interp_next),
    .remaining (x_q[FRAC_W-1:0]),
    .y         (interp_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next state plus next values of the registered ROM/response controls
  always_comb begin
    state_d     = state;
    req_ready   = '0;
    accept      = 1'b0;
    rom_en_d    = 1'b0;
    rom_addr_d  = '0;
    load_base   = 1'b0;
    load_rsp    = 1'b0;
    rsp_valid_d = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant_id] = 1'b1;
          accept              = 1'b1;
`ifdef ACT_SCHED_INDEX_REUSE_EN
          if (tag_hit) begin
            state_d = CALC;
          end else
`endif
          begin
            state_d    = RD_BASE;
            rom_en_d   = 1'b1;
            rom_addr_d = sel_base_addr;
          end
        end
      end
      RD_BASE: begin
        state_d    = RD_NEXT;
        rom_en_d   = 1'b1;
        rom_addr_d = next_addr_f(cur_base_addr);
      end
      RD_NEXT: begin
        state_d   = WAIT_NEXT;
        load_base = 1'b1;
      end
      WAIT_NEXT: begin
        state_d     = RESP;
        load_rsp    = 1'b1;
        rsp_valid_d = 1'b1;
      end
`ifdef ACT_SCHED_INDEX_REUSE_EN
      CALC: begin
        state_d     = RESP;
        load_rsp    = 1'b1;
        rsp_valid_d = 1'b1;
      end
`endif
      RESP: begin
        if (rsp_ready) state_d = IDLE;
        else           rsp_valid_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      id_q      <= '0;
      x_q       <= '0;
      base_q    <= '0;
      rom_en    <= 1'b0;
      rom_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_y     <= '0;
    end else begin
      rom_en    <= rom_en_d;
      rom_addr  <= rom_addr_d;
      rsp_valid <= rsp_valid_d;
      if (accept) begin
        x_q    <= sel_x;
        id_q   <= grant_id;
        rr_ptr <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
      if (load_base) base_q <= rom_rdata;
      if (load_rsp) begin
        rsp_y  <= interp_y;
        rsp_id <= id_q;
      end
    end
  end

endmodule
